veri_bellegi_yanitlayici: RTL and testbench
===========================================

# veri_bellegi_yanitlayici

Responder side of the L1 data request/response interface: accepts load and store requests from the memory pipeline stage, services them from a local word-organised data RAM, and returns load data through a valid/ready response channel after a programmable latency. It stands in for the L1 data cache in core-level simulation and small FPGA builds, directly on the `l1v_istek_*` / `l1v_veri_*` ports of the memory stage.

## Interface
- `ADRES_BIT`, 10: word-address width; RAM holds 2^ADRES_BIT 32-bit words (default 4 KiB).
- `GECIKME`, 2: read latency from request accept to first `veri_gecerli_o` cycle; legal range 1..15.

- `clk_i`  input  1  single clock, all state on rising edge.
- `rst_i`  input  1  reset, asynchronous, active-low.
- `istek_adres_i`  input  32  byte address.
- `istek_gecerli_i`  input  1  request valid.
- `istek_onbellekleme_i`  input  1  cacheability hint; accepted, no functional effect.
- `istek_yaz_i`  input  1  1 = store, 0 = load.
- `istek_veri_i`  input  32  store data, byte lanes aligned to word.
- `istek_maske_i`  input  4  store byte enables; bit i writes `[8i+:8]`.
- `istek_hazir_o`  output  1  request ready.
- `veri_o`  output  32  load data, full word.
- `veri_gecerli_o`  output  1  load response valid.
- `veri_hazir_i`  input  1  response consumer ready.
- `hata_o`  output  1  sticky out-of-range flag (see Configuration).

## Operation
- Word index = `istek_adres_i[ADRES_BIT+1:2]`; bits [1:0] ignored (requester extracts bytes/halves); upper bits ignored unless `VB_ADRES_DENETIM_EN`.
- States: `BOS` (idle), `BEKLE` (latency count), `YANIT` (response held).
- `istek_hazir_o` = (state == `BOS`). Request accepted on edge where `istek_gecerli_i && istek_hazir_o`.
- Store accept: masked bytes written at that edge; unmasked bytes unchanged; mask 0000 writes nothing. No response generated; state stays `BOS` (back-to-back stores at one per cycle).
- Load accept: RAM word captured into response register at that edge. If `GECIKME`==1 go to `YANIT`; else load 4-bit counter with `GECIKME`-2, go to `BEKLE`.
- `BEKLE`: counter decrements each cycle; at 0 go to `YANIT`.
- `YANIT`: `veri_gecerli_o`=1, `veri_o` = captured word, both stable until handshake. On `veri_hazir_i`=1 transfer completes, next state `BOS`.
- Only one load outstanding; no requests accepted in `BEKLE`/`YANIT`.
- Captured data reflects RAM at accept edge (no later store can intervene).
- RAM contents not reset; undefined until written.

## Timing
- Reset values: state `BOS`, `istek_hazir_o`=1, `veri_gecerli_o`=0, `veri_o`=0, `hata_o`=0, counter 0.
- Load accepted at edge N: `veri_gecerli_o` high from cycle N+`GECIKME` (i.e. after edge N+`GECIKME`-1); with `veri_hazir_i` already 1, handshake at edge N+`GECIKME`, `istek_hazir_o` high again cycle N+`GECIKME`+1.
- Load throughput: one per `GECIKME`+1 cycles with ready consumer.
- `veri_hazir_i` low in `YANIT`: hold indefinitely, data stable.
- `veri_hazir_i` outside `YANIT`: ignored.
- Reset asserted mid-operation: immediate return to `BOS`, pending load discarded, no response emitted; stores committed before reset persist.
- `veri_o` registered; holds last response value after handshake.

## Configuration
- `VB_ADRES_DENETIM_EN` defined: request with any of `istek_adres_i[31:ADRES_BIT+2]` nonzero is out-of-range; store dropped (RAM unchanged), load still responds with latency `GECIKME` but `veri_o`=32'h0000_0000; `hata_o` set at accept edge, stays 1 until reset.
- Not defined: upper address bits ignored, addresses alias modulo RAM size; `hata_o` tied 0.

## Test plan
- Store 0x1122_3344 to 0x0000_0010 mask 1111, then load 0x10 (GECIKME=2) -> `veri_gecerli_o` 2 cycles after load accept, `veri_o`=0x1122_3344.
- Store 0xAABB_CCDD mask 0101 over above word, load 0x12 -> `veri_o`=0x11BB_33DD (address bits [1:0] ignored).
- Load with `veri_hazir_i` low 5 cycles -> `veri_gecerli_o`/`veri_o` stable 5 cycles, `istek_hazir_o`=0 throughout, returns to 1 the cycle after handshake.
- Four stores on consecutive cycles -> all accepted, `istek_hazir_o` never drops; readback correct.
- `rst_i` low in `BEKLE` -> `veri_gecerli_o` never asserts, `istek_hazir_o`=1 during/after reset; prior stores read back intact.
- With `VB_ADRES_DENETIM_EN`, ADRES_BIT=10: store 0xFFFF_FFFF to 0x0000_1000, load 0x0000_1000 -> `veri_o`=0, `hata_o`=1; load 0x0 -> unchanged content. Without macro -> same store overwrites word 0.

Source files
------------

// File: rtl/veri_bellegi_yanitlayici.sv
// -----------------------------------------------------------------------------
// veri_bellegi_yanitlayici
//
// Responder for the L1 data request/response interface. It services load and
// store requests from the memory pipeline stage out of a local word-organised
// data RAM. Load data comes back on a valid/ready response channel after
// GECIKME cycles. This block stands in for the L1 data cache in core-level
// simulation and in small FPGA builds.
//
// Parameters
//   ADRES_BIT : word-address width; the RAM holds 2^ADRES_BIT 32-bit words
//   GECIKME   : cycles from load accept to the first valid response (1..15)
//
// Ports
//   clk_i                : clock, all state on the rising edge
//   rst_i                : asynchronous reset, active low
//   istek_adres_i[31:0]  : byte address; bits [1:0] are ignored
//   istek_gecerli_i      : request valid
//   istek_onbellekleme_i : cacheability hint; has no functional effect
//   istek_yaz_i          : 1 = store, 0 = load
//   istek_veri_i[31:0]   : store data, byte lanes aligned to the word
//   istek_maske_i[3:0]   : store byte enables; bit i writes [8i+:8]
//   istek_hazir_o        : request ready (high only while idle)
//   veri_o[31:0]         : load response data; holds its value after handshake
//   veri_gecerli_o       : load response valid
//   veri_hazir_i         : response consumer ready
//   hata_o               : sticky out-of-range flag
//
// Optional feature
//   VB_ADRES_DENETIM_EN : when defined, any request whose address bits
//   [31:ADRES_BIT+2] are nonzero is out of range. An out-of-range store is
//   dropped. An out-of-range load still responds with normal latency, but
//   returns zero. hata_o is set and stays set until reset. When the macro is
//   not defined, the upper address bits alias and hata_o stays 0.
// -----------------------------------------------------------------------------
module veri_bellegi_yanitlayici #(
  parameter int ADRES_BIT = 10,
  parameter int GECIKME   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] istek_adres_i,
  input  logic        istek_gecerli_i,
  input  logic        istek_onbellekleme_i,
  input  logic        istek_yaz_i,
  input  logic [31:0] istek_veri_i,
  input  logic [3:0]  istek_maske_i,
  output logic        istek_hazir_o,
  output logic [31:0] veri_o,
  output logic        veri_gecerli_o,
  input  logic        veri_hazir_i,
  output logic        hata_o
);

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  localparam int         KELIME_SAYISI   = 1 << ADRES_BIT;
  // With GECIKME >= 2, the counter counts GECIKME-2 .. 0 in BEKLE. One cycle
  // is spent in BEKLE per count. The accept edge and the final BEKLE edge
  // make up the remaining two cycles of latency.
  localparam logic [3:0] SAYAC_BASLANGIC = (GECIKME >= 2) ? 4'(GECIKME - 2) : 4'd0;

  durum_t      r_durum;
  logic [3:0]  r_sayac;
  logic        r_hazir;
  logic        r_gecerli;
  logic [31:0] r_veri;
  logic        r_hata;
  logic [31:0] r_bellek [KELIME_SAYISI];

  logic [ADRES_BIT-1:0] w_indeks;
  logic                 w_kabul;
  logic                 w_aralik_disi;
  logic                 w_yazma;
  logic [31:0]          w_okuma_verisi;
  logic                 w_unused_bitler;

  assign w_indeks = istek_adres_i[ADRES_BIT+1:2];
  assign w_kabul  = istek_gecerli_i && r_hazir;

`ifdef VB_ADRES_DENETIM_EN
  assign w_aralik_disi = |istek_adres_i[31:ADRES_BIT+2];
`else
  assign w_aralik_disi = 1'b0;
`endif

  // Reset gating keeps a request that is presented during reset from
  // committing a store while the FSM is held idle.
  assign w_yazma        = rst_i && w_kabul && istek_yaz_i && !w_aralik_disi;
  assign w_okuma_verisi = w_aralik_disi ? 32'h0000_0000 : r_bellek[w_indeks];

  // Byte-offset bits, the cacheability hint and (in the aliasing build) the
  // upper address bits are intentionally unused.
  assign w_unused_bitler = ^{istek_onbellekleme_i, istek_adres_i[1:0],
                             istek_adres_i[31:ADRES_BIT+2]};

  // NOTE: the data RAM has no reset, so it maps onto plain block/distributed
  // RAM. Its contents are undefined until written and survive a core reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (w_yazma && istek_maske_i[b]) begin
        r_bellek[w_indeks][8*b +: 8] <= istek_veri_i[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch sees the pre-edge values of the other registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_durum   <= BOS;
      r_sayac   <= 4'd0;
      r_hazir   <= 1'b1;
      r_gecerli <= 1'b0;
      r_veri    <= 32'h0000_0000;
      r_hata    <= 1'b0;
    end else begin
      case (r_durum)
        BOS: begin
          if (w_kabul) begin
            if (w_aralik_disi) begin
              r_hata <= 1'b1;
            end
            // A store completes at the accept edge and leaves the FSM idle.
            if (!istek_yaz_i) begin
              r_veri  <= w_okuma_verisi;
              r_hazir <= 1'b0;
              if (GECIKME == 1) begin
                r_durum   <= YANIT;
                r_gecerli <= 1'b1;
              end else begin
                r_durum <= BEKLE;
                r_sayac <= SAYAC_BASLANGIC;
              end
            end
          end
        end

        BEKLE: begin
          if (r_sayac == 4'd0) begin
            r_durum   <= YANIT;
            r_gecerli <= 1'b1;
          end else begin
            r_sayac <= r_sayac - 4'd1;
          end
        end

        YANIT: begin
          // r_veri holds its value after handshake. Only valid drops.
          if (veri_hazir_i) begin
            r_durum   <= BOS;
            r_gecerli <= 1'b0;
            r_hazir   <= 1'b1;
          end
        end

        default: begin
          r_durum   <= BOS;
          r_gecerli <= 1'b0;
          r_hazir   <= 1'b1;
        end
      endcase
    end
  end

  assign istek_hazir_o  = r_hazir;
  assign veri_gecerli_o = r_gecerli;
  assign veri_o         = r_veri;
  assign hata_o         = r_hata;

endmodule

// File: tb/tb_veri_bellegi_yanitlayici.sv
// -----------------------------------------------------------------------------
// Testbench for veri_bellegi_yanitlayici (ADRES_BIT=10, GECIKME=2).
// A table of store/load vectors is applied first. Loads push their expected
// word onto a scoreboard queue, and a monitor pops and compares the queue on
// every response handshake. Hand-written sequences then cover latency,
// back-to-back stores, response back-pressure, reset during BEKLE and
// upper-address handling.
// -----------------------------------------------------------------------------
module tb_veri_bellegi_yanitlayici;

  localparam int ADRES_BIT = 10;
  localparam int GECIKME   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] istek_adres_i;
  logic        istek_gecerli_i;
  logic        istek_onbellekleme_i;
  logic        istek_yaz_i;
  logic [31:0] istek_veri_i;
  logic [3:0]  istek_maske_i;
  logic        istek_hazir_o;
  logic [31:0] veri_o;
  logic        veri_gecerli_o;
  logic        veri_hazir_i;
  logic        hata_o;

  veri_bellegi_yanitlayici #(
    .ADRES_BIT(ADRES_BIT),
    .GECIKME  (GECIKME)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .istek_adres_i       (istek_adres_i),
    .istek_gecerli_i     (istek_gecerli_i),
    .istek_onbellekleme_i(istek_onbellekleme_i),
    .istek_yaz_i         (istek_yaz_i),
    .istek_veri_i        (istek_veri_i),
    .istek_maske_i       (istek_maske_i),
    .istek_hazir_o       (istek_hazir_o),
    .veri_o              (veri_o),
    .veri_gecerli_o      (veri_gecerli_o),
    .veri_hazir_i        (veri_hazir_i),
    .hata_o              (hata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        yaz;
    logic [31:0] adres;
    logic [31:0] veri;
    logic [3:0]  maske;
    logic [31:0] beklenen;
  } vektor_t;

  vektor_t     vektorler [12];
  logic [31:0] sb_q [$];
  logic [31:0] mon_beklenen;
  int          n_kontrol = 0;
  int          n_hata    = 0;

  task automatic check(input string ad, input logic [31:0] gercek,
                       input logic [31:0] beklenen);
    n_kontrol++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s: gercek=%h beklenen=%h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  // Inputs change at negedge+1. The monitor looks at negedge+2, when the
  // inputs for the coming edge are settled. It compares each handshake
  // against the scoreboard.
  always @(negedge clk_i) begin
    #2;
    if (rst_i === 1'b1 && veri_gecerli_o === 1'b1 && veri_hazir_i === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("beklenmeyen_yanit", 32'd1, 32'd0);
      end else begin
        mon_beklenen = sb_q.pop_front();
        check("yanit_verisi", veri_o, mon_beklenen);
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 after the accept edge with the
  // request withdrawn, so consecutive calls issue on consecutive cycles.
  task automatic istek(input logic yaz, input logic [31:0] adres,
                       input logic [31:0] veri, input logic [3:0] maske,
                       input logic [31:0] beklenen, input bit hazir_denetle);
    int butce;
    istek_yaz_i     = yaz;
    istek_adres_i   = adres;
    istek_veri_i    = veri;
    istek_maske_i   = maske;
    istek_gecerli_i = 1'b1;
    if (hazir_denetle) check("arka_arkaya_hazir", {31'd0, istek_hazir_o}, 32'd1);
    butce = 50;
    while (istek_hazir_o !== 1'b1 && butce > 0) begin
      @(negedge clk_i); #1;
      butce--;
    end
    if (butce == 0) check("istek_zaman_asimi", 32'd0, 32'd1);
    @(posedge clk_i);
    if (!yaz) sb_q.push_back(beklenen);
    @(negedge clk_i); #1;
    istek_gecerli_i = 1'b0;
  endtask

  task automatic bosta_bekle();
    int butce;
    butce = 100;
    while ((istek_hazir_o !== 1'b1 || sb_q.size() != 0) && butce > 0) begin
      @(negedge clk_i); #1;
      butce--;
    end
    if (butce == 0) check("bosta_zaman_asimi", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int butce;
    rst_i                = 1'b0;
    istek_adres_i        = '0;
    istek_gecerli_i      = 1'b0;
    istek_onbellekleme_i = 1'b1;
    istek_yaz_i          = 1'b0;
    istek_veri_i         = '0;
    istek_maske_i        = '0;
    veri_hazir_i         = 1'b1;

    // Reset values
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_istek_hazir", {31'd0, istek_hazir_o}, 32'd1);
    check("reset_veri_gecerli", {31'd0, veri_gecerli_o}, 32'd0);
    check("reset_veri", veri_o, 32'h0000_0000);
    check("reset_hata", {31'd0, hata_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i); #1;

    // Table-driven store/load vectors
    vektorler[0]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0};
    vektorler[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h1122_3344};
    vektorler[2]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0};
    vektorler[3]  = '{1'b0, 32'h0000_0012, 32'h0,         4'b0000, 32'h11BB_33DD};
    vektorler[4]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vektorler[5]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'b1000, 32'h0};
    vektorler[6]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0000, 32'h0};
    vektorler[7]  = '{1'b0, 32'h0000_0023, 32'h0,         4'b0000, 32'h00AD_BEEF};
    vektorler[8]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vektorler[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'hCAFE_F00D};
    vektorler[10] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'b1111, 32'h0};
    vektorler[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0102_0304};
    for (int i = 0; i < 12; i++) begin
      istek(vektorler[i].yaz, vektorler[i].adres, vektorler[i].veri,
            vektorler[i].maske, vektorler[i].beklenen, 1'b0);
    end
    bosta_bekle();

    // Latency: valid rises after edge N+GECIKME-1 and ready returns after
    // the handshake edge N+GECIKME.
    istek(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h11BB_33DD, 1'b0);
    for (int j = 0; j < GECIKME; j++) begin
      if (j > 0) begin
        @(negedge clk_i); #1;
      end
      check("gecikme_gecerli", {31'd0, veri_gecerli_o}, (j == GECIKME - 1) ? 32'd1 : 32'd0);
      check("gecikme_istek_hazir", {31'd0, istek_hazir_o}, 32'd0);
    end
    @(negedge clk_i); #1;
    check("el_sikisma_sonrasi_hazir", {31'd0, istek_hazir_o}, 32'd1);
    check("el_sikisma_sonrasi_gecerli", {31'd0, veri_gecerli_o}, 32'd0);

    // Four stores on consecutive cycles, ready must never drop
    istek(1'b1, 32'h0000_0040, 32'hA0A1_A2A3, 4'b1111, 32'h0, 1'b1);
    istek(1'b1, 32'h0000_0044, 32'hB0B1_B2B3, 4'b1111, 32'h0, 1'b1);
    istek(1'b1, 32'h0000_0048, 32'hC0C1_C2C3, 4'b1111, 32'h0, 1'b1);
    istek(1'b1, 32'h0000_004C, 32'hD0D1_D2D3, 4'b1111, 32'h0, 1'b1);
    check("arka_arkaya_son_hazir", {31'd0, istek_hazir_o}, 32'd1);
    istek(1'b0, 32'h0000_0040, 32'h0, 4'b0000, 32'hA0A1_A2A3, 1'b0);
    istek(1'b0, 32'h0000_0044, 32'h0, 4'b0000, 32'hB0B1_B2B3, 1'b0);
    istek(1'b0, 32'h0000_0048, 32'h0, 4'b0000, 32'hC0C1_C2C3, 1'b0);
    istek(1'b0, 32'h0000_004C, 32'h0, 4'b0000, 32'hD0D1_D2D3, 1'b0);
    bosta_bekle();

    // Response back-pressure: held for 5 cycles with data stable
    veri_hazir_i = 1'b0;
    istek(1'b0, 32'h0000_0048, 32'h0, 4'b0000, 32'hC0C1_C2C3, 1'b0);
    butce = 50;
    while (veri_gecerli_o !== 1'b1 && butce > 0) begin
      @(negedge clk_i); #1;
      butce--;
    end
    if (butce == 0) check("bekletme_zaman_asimi", 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bekletme_gecerli", {31'd0, veri_gecerli_o}, 32'd1);
      check("bekletme_veri", veri_o, 32'hC0C1_C2C3);
      check("bekletme_istek_hazir", {31'd0, istek_hazir_o}, 32'd0);
      @(negedge clk_i); #1;
    end
    veri_hazir_i = 1'b1;
    @(negedge clk_i); #1;
    check("bekletme_sonu_hazir", {31'd0, istek_hazir_o}, 32'd1);
    check("bekletme_sonu_gecerli", {31'd0, veri_gecerli_o}, 32'd0);
    check("bekletme_sonu_veri_tutulur", veri_o, 32'hC0C1_C2C3);

    // Reset while in BEKLE: the pending load is discarded
    istek(1'b1, 32'h0000_0080, 32'h0BAD_CAFE, 4'b1111, 32'h0, 1'b0);
    istek(1'b0, 32'h0000_0080, 32'h0, 4'b0000, 32'h0BAD_CAFE, 1'b0);
    rst_i = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check("reset_bekle_gecerli", {31'd0, veri_gecerli_o}, 32'd0);
    check("reset_bekle_hazir", {31'd0, istek_hazir_o}, 32'd1);
    @(negedge clk_i); #1;
    check("reset_icinde_hazir", {31'd0, istek_hazir_o}, 32'd1);
    rst_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i); #1;
      check("reset_sonrasi_gecerli", {31'd0, veri_gecerli_o}, 32'd0);
      check("reset_sonrasi_hazir", {31'd0, istek_hazir_o}, 32'd1);
    end
    check("reset_sonrasi_hata", {31'd0, hata_o}, 32'd0);
    istek(1'b0, 32'h0000_0080, 32'h0, 4'b0000, 32'h0BAD_CAFE, 1'b0);
    istek(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h11BB_33DD, 1'b0);
    bosta_bekle();

    // Upper address bits: range-checked or aliased depending on the build
    istek(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b0);
`ifdef VB_ADRES_DENETIM_EN
    check("aralik_disi_hata_yazma", {31'd0, hata_o}, 32'd1);
    istek(1'b0, 32'h0000_1000, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);
    istek(1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0102_0304, 1'b0);
    bosta_bekle();
    check("aralik_disi_hata_kalici", {31'd0, hata_o}, 32'd1);
`else
    istek(1'b0, 32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    istek(1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    bosta_bekle();
    check("takma_ad_hata_sifir", {31'd0, hata_o}, 32'd0);
`endif

    check("skorbord_bos", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_kontrol, n_hata);
    $finish;
  end

endmodule
